// File: rtl/uart_boot_rx_pkg.sv
// Shared constants for the UART boot-load receiver: bus widths, frame size and
// receiver state encodings.
package uart_boot_rx_pkg;

   localparam int DATABUS         = 16;
   localparam int BYTE_CNT_W      = 16;
   localparam int UART_FRAME_BITS = 8;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   function automatic int bit_cycles(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_boot_rx_if.sv
// Byte-stream bus from the UART receiver to the instruction-ROM loader.
interface uart_boot_rx_if;
   import uart_boot_rx_pkg::*;

   logic                  ctrl;
   logic [DATABUS-1:0]    wdata;
   logic                  frame_err;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic                  load_done;

   modport master (output ctrl, wdata, frame_err, byte_cnt, load_done);
   modport slave  (input  ctrl, wdata, frame_err, byte_cnt, load_done);

endinterface

// File: rtl/uart_boot_rx_phy.sv
// 8N1 receive PHY: input synchroniser, frame FSM and mid-bit sampling.
// Emits combinational sample-cycle strobes; the top level registers them.
module uart_boot_rx_phy
   import uart_boot_rx_pkg::*;
#(
   parameter int BIT_CYC = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_en,
   input  logic                       i_rx,
   output logic                       o_start,
   output logic                       o_idle,
   output logic                       o_byte_vld,
   output logic                       o_frame_err,
   output logic [UART_FRAME_BITS-1:0] o_byte
);

   localparam int                BCNT_W   = $clog2(BIT_CYC);
   localparam logic [BCNT_W-1:0] HALF_END = BCNT_W'(BIT_CYC / 2 - 1);
   localparam logic [BCNT_W-1:0] BIT_END  = BCNT_W'(BIT_CYC - 1);
   localparam logic [2:0]        LAST_BIT = 3'(UART_FRAME_BITS - 1);

   logic [1:0]                 r_sync;
   uart_state_e                r_state;
   logic [BCNT_W-1:0]          r_bcnt;
   logic [2:0]                 r_bidx;
   logic [UART_FRAME_BITS-1:0] r_sh;
   logic                       w_rx_s;
   logic                       w_bit_end;

   assign w_rx_s    = r_sync[1];
   assign w_bit_end = (r_bcnt == BIT_END);

   assign o_idle      = (r_state == UART_IDLE);
   assign o_start     = i_en && o_idle && !w_rx_s;
   assign o_byte_vld  = i_en && (r_state == UART_STOP) && w_bit_end &&  w_rx_s;
   assign o_frame_err = i_en && (r_state == UART_STOP) && w_bit_end && !w_rx_s;
   assign o_byte      = r_sh;

   // Synchroniser runs regardless of enable so rx_s is settled when en rises.
   always_ff @(posedge clk) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], i_rx};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= UART_IDLE;
         r_bcnt  <= '0;
         r_bidx  <= '0;
         r_sh    <= '0;
      end else if (!i_en) begin
         r_state <= UART_IDLE;
         r_bcnt  <= '0;
         r_bidx  <= '0;
      end else begin
         case (r_state)
            UART_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= UART_START;
                  r_bcnt  <= '0;
               end
            end
            UART_START: begin
               if (r_bcnt == HALF_END) begin
                  r_bcnt  <= '0;
                  r_bidx  <= '0;
                  r_state <= w_rx_s ? UART_IDLE : UART_DATA;
               end else begin
                  r_bcnt <= r_bcnt + 1'b1;
               end
            end
            UART_DATA: begin
               if (w_bit_end) begin
                  r_bcnt <= '0;
                  r_sh   <= {w_rx_s, r_sh[UART_FRAME_BITS-1:1]};
                  if (r_bidx == LAST_BIT) r_state <= UART_STOP;
                  else                    r_bidx  <= r_bidx + 1'b1;
               end else begin
                  r_bcnt <= r_bcnt + 1'b1;
               end
            end
            UART_STOP: begin
               // Leave at mid-stop so a start bit right after the stop bit is caught.
               if (w_bit_end) begin
                  r_bcnt  <= '0;
                  r_state <= UART_IDLE;
               end else begin
                  r_bcnt <= r_bcnt + 1'b1;
               end
            end
            default: r_state <= UART_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_boot_rx.sv
// UART boot-load front end: enable gating, byte strobe/wdata formatting,
// received-byte counter and idle-timeout end-of-load flag.
module uart_boot_rx
   import uart_boot_rx_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_en,
   input  logic           i_rx,
   uart_boot_rx_if.master bus
);

   localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
   localparam int TMO     = TIMEOUT_BITS * BIT_CYC;
   localparam int TMR_W   = $clog2(TMO + 1);

   logic                       w_start;
   logic                       w_idle;
   logic                       w_byte_vld;
   logic                       w_frame_err;
   logic [UART_FRAME_BITS-1:0] w_byte;

   logic                  r_ctrl;
   logic                  r_ferr;
   logic [DATABUS-1:0]    r_wdata;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic [TMR_W-1:0]      r_timer;
   logic                  r_load_done;

   uart_boot_rx_phy #(.BIT_CYC(BIT_CYC)) u_phy (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (i_en),
      .i_rx        (i_rx),
      .o_start     (w_start),
      .o_idle      (w_idle),
      .o_byte_vld  (w_byte_vld),
      .o_frame_err (w_frame_err),
      .o_byte      (w_byte)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ctrl      <= 1'b0;
         r_ferr      <= 1'b0;
         r_wdata     <= '0;
         r_byte_cnt  <= '0;
         r_timer     <= '0;
         r_load_done <= 1'b0;
      end else if (!i_en) begin
         r_ctrl      <= 1'b0;
         r_ferr      <= 1'b0;
         r_byte_cnt  <= '0;
         r_timer     <= '0;
         r_load_done <= 1'b0;
      end else begin
         r_ctrl <= w_byte_vld;
         r_ferr <= w_frame_err;
         if (w_byte_vld) begin
            r_wdata    <= {{(DATABUS-UART_FRAME_BITS){1'b0}}, w_byte};
            r_byte_cnt <= r_byte_cnt + 16'd1;
         end
         // A start bit outranks a coincident timeout so load_done stays low.
         if (w_start) begin
            r_timer     <= '0;
            r_load_done <= 1'b0;
         end else if (w_idle && (r_byte_cnt != '0)) begin
            if (r_timer == TMR_W'(TMO)) r_load_done <= 1'b1;
            else                        r_timer     <= r_timer + TMR_W'(1);
         end
      end
   end

   assign bus.ctrl      = r_ctrl;
   assign bus.frame_err = r_ferr;
   assign bus.wdata     = r_wdata;
   assign bus.byte_cnt  = r_byte_cnt;
   assign bus.load_done = r_load_done;

endmodule

// File: tb/tb_uart_boot_rx.sv
// Randomised bench for uart_boot_rx: serial frames driven bit by bit, checked
// against a byte-level model (expected byte list, count, last word).
module tb_uart_boot_rx;
   import uart_boot_rx_pkg::*;

   localparam int BC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic rx = 1'b1;

   uart_boot_rx_if bus ();

   uart_boot_rx #(.CLK_FREQ(16), .BAUD(1), .TIMEOUT_BITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (en),
      .i_rx  (rx),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // reference model
   logic [15:0] exp_q[$];
   int          exp_cnt   = 0;
   logic [15:0] exp_wdata = 16'h0000;

   // monitor
   logic [15:0] got_q[$];
   int   n_ctrl = 0, n_ferr = 0, n_viol = 0;
   logic prev_ctrl = 1'b0, prev_ferr = 1'b0, prev_rst = 1'b0;
   logic [15:0] prev_wdata = 16'h0000;

   always @(negedge clk) begin
      if (rst_n && prev_rst) begin
         if (bus.ctrl && bus.frame_err) n_viol++;
         if (bus.ctrl && prev_ctrl) n_viol++;
         if (bus.frame_err && prev_ferr) n_viol++;
         if (!bus.ctrl && bus.wdata !== prev_wdata) n_viol++;
      end
      if (bus.ctrl === 1'b1) begin
         n_ctrl++;
         got_q.push_back(bus.wdata);
      end
      if (bus.frame_err === 1'b1) n_ferr++;
      prev_ctrl  = bus.ctrl;
      prev_ferr  = bus.frame_err;
      prev_wdata = bus.wdata;
      prev_rst   = rst_n;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_tail(input logic [7:0] b, input logic stop);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BC);
      end
      rx = stop;
      tick(BC);
      rx = 1'b1;
      if (stop && en) begin
         exp_q.push_back({8'h00, b});
         exp_cnt   = (exp_cnt + 1) % 65536;
         exp_wdata = {8'h00, b};
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(BC);
      send_tail(b, stop);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         tick(1);
      end
      checks++; if (bus.ctrl !== 1'b0) $display("FAIL reset_ctrl: got %b want 0", bus.ctrl); else passes++;
      checks++; if (bus.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", bus.frame_err); else passes++;
      checks++; if (bus.wdata !== 16'h0000) $display("FAIL reset_wdata: got %h want 0000", bus.wdata); else passes++;
      checks++; if (bus.byte_cnt !== 16'h0000) $display("FAIL reset_cnt: got %h want 0000", bus.byte_cnt); else passes++;
      checks++; if (bus.load_done !== 1'b0) $display("FAIL reset_load_done: got %b want 0", bus.load_done); else passes++;
      checks++; if (dut.u_phy.r_sync !== 2'b11) $display("FAIL reset_sync: got %b want 11", dut.u_phy.r_sync); else passes++;
      rx = 1'b1;
      rst_n = 1'b1;
      tick(3);
      checks++; if (dut.u_phy.r_state !== UART_IDLE) $display("FAIL reset_state: got %0d want %0d", dut.u_phy.r_state, UART_IDLE); else passes++;
      checks++; if (n_ctrl != 0 || n_ferr != 0) $display("FAIL reset_strobes: got ctrl=%0d ferr=%0d want 0/0", n_ctrl, n_ferr); else passes++;
   endtask

   task automatic test_single;
      int c0 = n_ctrl, f0 = n_ferr;
      send_frame(8'hA5, 1'b1);
      tick(4);
      checks++; if (n_ctrl - c0 != 1) $display("FAIL single_ctrl_pulses: got %0d want 1", n_ctrl - c0); else passes++;
      checks++; if (bus.wdata !== 16'h00A5) $display("FAIL single_wdata: got %h want 00a5", bus.wdata); else passes++;
      checks++; if (bus.byte_cnt !== 16'(exp_cnt)) $display("FAIL single_cnt: got %h want %h", bus.byte_cnt, 16'(exp_cnt)); else passes++;
      checks++; if (n_ferr != f0) $display("FAIL single_ferr: got %0d want 0", n_ferr - f0); else passes++;
   endtask

   task automatic test_back_to_back;
      logic [7:0] b3 = 8'($urandom);
      en = 1'b0;
      tick(2);
      en = 1'b1;
      exp_cnt = 0;
      exp_q.delete();
      got_q.delete();
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      tick(2);
      checks++; if (bus.byte_cnt !== 16'd2) $display("FAIL b2b_cnt: got %h want 0002", bus.byte_cnt); else passes++;
      tick(30);
      checks++; if (bus.load_done !== 1'b0) $display("FAIL b2b_early_load_done: got %b want 0", bus.load_done); else passes++;
      for (int i = 0; i < 64 && bus.load_done !== 1'b1; i++) tick(1);
      checks++; if (bus.load_done !== 1'b1) $display("FAIL b2b_timeout: got %b want 1", bus.load_done); else passes++;
      rx = 1'b0;
      tick(4);
      checks++; if (bus.load_done !== 1'b0) $display("FAIL b2b_start_clears: got %b want 0", bus.load_done); else passes++;
      tick(BC - 4);
      send_tail(b3, 1'b1);
      tick(2);
      checks++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
      else begin
         passes++;
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); else passes++;
         end
      end
   endtask

   task automatic test_frame_err;
      int c0 = n_ctrl, f0 = n_ferr;
      send_frame(8'h3C, 1'b0);
      tick(2 * BC);
      checks++; if (n_ferr - f0 != 1) $display("FAIL ferr_pulses: got %0d want 1", n_ferr - f0); else passes++;
      checks++; if (n_ctrl != c0) $display("FAIL ferr_no_ctrl: got %0d want 0", n_ctrl - c0); else passes++;
      checks++; if (bus.wdata !== exp_wdata) $display("FAIL ferr_wdata: got %h want %h", bus.wdata, exp_wdata); else passes++;
      checks++; if (bus.byte_cnt !== 16'(exp_cnt)) $display("FAIL ferr_cnt: got %h want %h", bus.byte_cnt, 16'(exp_cnt)); else passes++;
      send_frame(8'h55, 1'b1);
      tick(4);
      checks++; if (bus.wdata !== 16'h0055) $display("FAIL ferr_recover_wdata: got %h want 0055", bus.wdata); else passes++;
      checks++; if (bus.byte_cnt !== 16'(exp_cnt)) $display("FAIL ferr_recover_cnt: got %h want %h", bus.byte_cnt, 16'(exp_cnt)); else passes++;
   endtask

   task automatic test_glitch;
      int c0 = n_ctrl, f0 = n_ferr;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(30);
      checks++; if (n_ctrl != c0 || n_ferr != f0) $display("FAIL glitch_strobes: got ctrl=%0d ferr=%0d want 0/0", n_ctrl - c0, n_ferr - f0); else passes++;
      checks++; if (dut.u_phy.r_state !== UART_IDLE) $display("FAIL glitch_state: got %0d want %0d", dut.u_phy.r_state, UART_IDLE); else passes++;
   endtask

   task automatic test_random;
      exp_q.delete();
      got_q.delete();
      for (int n = 0; n < 12; n++) begin
         logic [7:0] b = 8'($urandom);
         logic stop = ($urandom_range(3) != 0);
         send_frame(b, stop);
         tick(stop ? $urandom_range(20) : 2 * BC + $urandom_range(8));
      end
      tick(4);
      checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
      else begin
         passes++;
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); else passes++;
         end
      end
      checks++; if (bus.byte_cnt !== 16'(exp_cnt)) $display("FAIL rand_cnt: got %h want %h", bus.byte_cnt, 16'(exp_cnt)); else passes++;
   endtask

   task automatic test_enable_wrap;
      int c0 = n_ctrl, f0 = n_ferr;
      logic [7:0] b = 8'($urandom);
      rx = 1'b0;
      tick(BC);
      rx = 1'b1;
      tick(3 * BC);
      en = 1'b0;
      exp_cnt = 0;
      tick(2);
      checks++; if (bus.byte_cnt !== 16'h0000) $display("FAIL en_cnt_clear: got %h want 0000", bus.byte_cnt); else passes++;
      checks++; if (bus.load_done !== 1'b0) $display("FAIL en_load_done: got %b want 0", bus.load_done); else passes++;
      tick(6 * BC);
      checks++; if (n_ctrl != c0 || n_ferr != f0) $display("FAIL en_abort_strobes: got ctrl=%0d ferr=%0d want 0/0", n_ctrl - c0, n_ferr - f0); else passes++;
      en = 1'b1;
      tick(BC);
      force dut.r_byte_cnt = 16'hFFFF;
      tick(2);
      release dut.r_byte_cnt;
      exp_cnt = 16'hFFFF;
      tick(1);
      send_frame(b, 1'b1);
      tick(4);
      checks++; if (bus.byte_cnt !== 16'(exp_cnt)) $display("FAIL wrap_cnt: got %h want %h", bus.byte_cnt, 16'(exp_cnt)); else passes++;
      checks++; if (bus.wdata !== exp_wdata) $display("FAIL wrap_wdata: got %h want %h", bus.wdata, exp_wdata); else passes++;
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_frame_err;
      test_glitch;
      test_random;
      test_enable_wrap;
      checks++; if (n_viol != 0) $display("FAIL strobe_rules: got %0d violations want 0", n_viol); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
